// File: rtl/md_unit.sv
// -----------------------------------------------------------------------------
// md_unit -- multiply/divide unit for the five-stage MIPS pipeline.
//
// This unit owns the HI/LO registers. EX issues MULT/MULTU/DIV/DIVU/MTHI/MTLO
// with a one-cycle start strobe. The result is computed on the start edge and
// held in pending registers. HI/LO update when a fixed latency expires, and busy
// is high for that whole latency.
//
// Optional feature macro: MD_MADD_EN
//   When it is defined, ops 7 (MADD) and 8 (MADDU) accumulate a signed or
//   unsigned product into {HI,LO}. When it is undefined, those ops have no
//   effect.
//
// Handshake: start is a one-cycle strobe qualified by op. It is accepted only
// while busy is low; a start seen while busy is high is dropped without any
// side effect. busy is a registered output. The cycle after the final busy
// cycle is the first cycle in which the new HI/LO values are visible.
//
// Ports:
//   clk        in   1   clock, all state changes on posedge
//   reset      in   1   synchronous, active-high
//   start      in   1   issue strobe from EX
//   op         in   4   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo,
//                       7 madd,8 maddu
//   a          in  32   operand rs
//   b          in  32   operand rt
//   busy       out  1   operation in flight
//   hi         out 32   HI register
//   lo         out 32   LO register
//   dbg_state  out  1   FSM state (0 IDLE, 1 RUN) for debug/checkers
// -----------------------------------------------------------------------------
module md_unit #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        dbg_state
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MD_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
`endif

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  // When this is clear, completion leaves HI/LO untouched (divide by zero).
  logic             pend_wr_q, pend_wr_d;

  // ---------------------------------------------------------------------------
  // Datapath: one shared multiplier and one shared divider, both fed with
  // operands that are already prepared for signed or unsigned operation.
  // ---------------------------------------------------------------------------
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, prod;
  logic [63:0] acc_sum;

  // For the signed case, sign-extending both operands to 64 bits makes the low
  // 64 bits of the product equal to the 64-bit two's-complement product.
`ifdef MD_MADD_EN
  assign mul_signed = (op == OP_MULT) || (op == OP_MADD);
`else
  assign mul_signed = (op == OP_MULT);
`endif
  assign mul_a   = mul_signed ? {{32{a[31]}}, a} : {32'd0, a};
  assign mul_b   = mul_signed ? {{32{b[31]}}, b} : {32'd0, b};
  assign prod    = mul_a * mul_b;
  assign acc_sum = {hi_q, lo_q} + prod;

  logic        div_signed;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [31:0] dvd, dvs, dvs_safe;
  logic [31:0] quo_u, rem_u;
  logic [31:0] div_lo, div_hi;

  // The signed divide works on magnitudes, then fixes the signs: the quotient
  // is negated when the operand signs differ, which truncates toward zero, and
  // the remainder takes the dividend's sign. The magnitude of 0x80000000 is
  // still 0x80000000 as an unsigned value, so 0x80000000 / -1 gives
  // 0x80000000 with a remainder of 0 and no special case is needed.
  assign div_signed = (op == OP_DIV);
  assign a_neg      = div_signed & a[31];
  assign b_neg      = div_signed & b[31];
  assign a_mag      = a_neg ? (~a + 32'd1) : a;
  assign b_mag      = b_neg ? (~b + 32'd1) : b;
  assign dvd        = a_mag;
  assign dvs        = b_mag;
  // A divisor of zero is replaced by 1 only to keep the operator defined; that
  // result is discarded through pend_wr.
  assign dvs_safe   = (dvs == 32'd0) ? 32'd1 : dvs;
  assign quo_u      = dvd / dvs_safe;
  assign rem_u      = dvd % dvs_safe;
  assign div_lo     = (a_neg ^ b_neg) ? (~quo_u + 32'd1) : quo_u;
  assign div_hi     = a_neg ? (~rem_u + 32'd1) : rem_u;

  // ---------------------------------------------------------------------------
  // Next-state and register-update logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              pend_hi_d = prod[63:32];
              pend_lo_d = prod[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYC);
              state_d   = S_RUN;
            end
            OP_DIV, OP_DIVU: begin
              pend_hi_d = div_hi;
              pend_lo_d = div_lo;
              pend_wr_d = (b != 32'd0);
              cnt_d     = CNT_W'(DIV_CYC);
              state_d   = S_RUN;
            end
`ifdef MD_MADD_EN
            OP_MADD, OP_MADDU: begin
              // The {HI,LO} addend is taken at the start edge.
              pend_hi_d = acc_sum[63:32];
              pend_lo_d = acc_sum[31:0];
              pend_wr_d = 1'b1;
              cnt_d     = CNT_W'(MULT_CYC);
              state_d   = S_RUN;
            end
`endif
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;  // none or undefined: no effect
          endcase
        end
      end
      S_RUN: begin
        // Any start seen while busy is ignored.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          pend_wr_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign hi        = hi_q;
  assign lo        = lo_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_md_unit.sv
// -----------------------------------------------------------------------------
// tb_md_unit -- testbench for md_unit.
//
// Expected HI/LO values come from a reference function that uses plain integer
// arithmetic. Expected busy lengths come from the op class.
// -----------------------------------------------------------------------------
module tb_md_unit;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  int checks   = 0;
  int failures = 0;

  // Reference HI/LO state, plus the expected {hi,lo} of each issued op.
  logic [31:0] mdl_hi, mdl_lo;
  logic [63:0] exp_q[$];

  md_unit #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Applies one op to the {hi,lo} state and returns the expected busy length.
  function automatic int md_model(input logic [3:0] mop, input logic [31:0] ma,
                                  input logic [31:0] mb,
                                  inout logic [31:0] rhi, inout logic [31:0] rlo);
    longint sa, sb, sq, sr;
    logic [63:0] ua, ub, p, q, r;
    int cyc;
    sa  = longint'($signed(ma));
    sb  = longint'($signed(mb));
    ua  = {32'd0, ma};
    ub  = {32'd0, mb};
    cyc = 0;
    case (mop)
      4'd1: begin p = 64'(sa * sb); {rhi, rlo} = p; cyc = MULT_CYC; end
      4'd2: begin p = ua * ub;      {rhi, rlo} = p; cyc = MULT_CYC; end
      4'd3: begin
        cyc = DIV_CYC;
        if (mb != 0) begin
          sq = sa / sb; sr = sa % sb;
          q = 64'(sq); r = 64'(sr);
          rlo = q[31:0]; rhi = r[31:0];
        end
      end
      4'd4: begin
        cyc = DIV_CYC;
        if (mb != 0) begin
          q = ua / ub; r = ua % ub;
          rlo = q[31:0]; rhi = r[31:0];
        end
      end
      4'd5: rhi = ma;
      4'd6: rlo = ma;
`ifdef MD_MADD_EN
      4'd7: begin p = {rhi, rlo} + 64'(sa * sb); {rhi, rlo} = p; cyc = MULT_CYC; end
      4'd8: begin p = {rhi, rlo} + ua * ub;      {rhi, rlo} = p; cyc = MULT_CYC; end
`endif
      default: ;
    endcase
    return cyc;
  endfunction

  // ---------------- driver tasks ----------------
  // Issues one op. If intrude is set, it also fires a stray MTHI while busy.
  // It then counts busy cycles within a bounded budget and checks the busy
  // length and the final HI/LO.
  task automatic run_op(input string tag, input logic [3:0] top, input logic [31:0] ta,
                        input logic [31:0] tb, input bit intrude);
    int exp_cyc, n;
    logic [63:0] exp_v;
    exp_cyc = md_model(top, ta, tb, mdl_hi, mdl_lo);
    exp_q.push_back({mdl_hi, mdl_lo});
    @(negedge clk);
    start = 1'b1; op = top; a = ta; b = tb;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      n++;
      if (intrude && n == 1) begin
        start = 1'b1; op = 4'd5; a = $urandom;
      end else begin
        start = 1'b0; op = 4'd0;
      end
      @(negedge clk);
    end
    start = 1'b0; op = 4'd0;
    exp_v = exp_q.pop_front();
    check({tag, "_busy_cycles"}, 64'(n), 64'(exp_cyc));
    check({tag, "_hilo"}, {hi, lo}, exp_v);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [3:0] rop;
    start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
    reset = 1'b1;
    mdl_hi = 32'd0; mdl_lo = 32'd0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    check("reset_state", 64'(dbg_state), 64'd0);
    reset = 1'b0;

    // 1. mult -2 * 3
    run_op("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    check("mult_neg_exact", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    // 2. divu / div
    run_op("divu_17_5", 4'd4, 32'd17, 32'd5, 1'b0);
    check("divu_exact", {hi, lo}, {32'd2, 32'd3});
    run_op("div_m17_5", 4'd3, 32'hFFFF_FFEF, 32'd5, 1'b0);
    check("div_exact", {hi, lo}, {32'hFFFF_FFFE, 32'hFFFF_FFFD});

    // 3. back-to-back mthi/mtlo; busy must never rise
    @(negedge clk);
    start = 1'b1; op = 4'd5; a = 32'h1234_5678;
    @(negedge clk);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'h1234_5678);
    op = 4'd6; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    check("mtlo_busy", 64'(busy), 64'd0);
    check("mt_hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    mdl_hi = 32'h1234_5678; mdl_lo = 32'h9ABC_DEF0;

    // 4. divide by zero leaves HI/LO; overflow case
    run_op("pre_hi", 4'd5, 32'd1, 32'd0, 1'b0);
    run_op("pre_lo", 4'd6, 32'd2, 32'd0, 1'b0);
    run_op("div_by0", 4'd3, 32'd77, 32'd0, 1'b0);
    check("div_by0_exact", {hi, lo}, {32'd1, 32'd2});
    run_op("divu_by0", 4'd4, 32'd5, 32'd0, 1'b0);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_exact", {hi, lo}, {32'd0, 32'h8000_0000});

    // start while busy is ignored
    run_op("mult_intrude", 4'd1, 32'd1234, 32'hFFFF_0000, 1'b1);
    run_op("div_intrude", 4'd3, 32'h8765_4321, 32'd99, 1'b1);

    // undefined ops: no effect
    run_op("op_none", 4'd0, 32'hDEAD_BEEF, 32'd1, 1'b0);
    run_op("op_undef9", 4'd9, 32'hDEAD_BEEF, 32'd1, 1'b0);
    run_op("op_undef15", 4'd15, 32'hDEAD_BEEF, 32'd1, 1'b0);

    // 6. madd / maddu, or no effect when the feature is absent
    run_op("pre0_hi", 4'd5, 32'd0, 32'd0, 1'b0);
    run_op("pre0_lo", 4'd6, 32'hFFFF_FFFF, 32'd0, 1'b0);
    run_op("maddu_carry", 4'd8, 32'd1, 32'd1, 1'b0);
`ifdef MD_MADD_EN
    check("maddu_exact", {hi, lo}, {32'd1, 32'd0});
`else
    check("maddu_absent", {hi, lo}, {32'd0, 32'hFFFF_FFFF});
`endif
    run_op("madd_neg", 4'd7, 32'hFFFF_FFFF, 32'd3, 1'b0);

    // randomized ops
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      rop = (k < 8) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
      run_op($sformatf("rnd%0d_op%0d", i, rop), rop, rand_operand(), rand_operand(),
             ($urandom_range(0, 3) == 0));
    end

    // 5. reset during the third busy cycle of multu aborts the op
    @(negedge clk);
    start = 1'b1; op = 4'd2; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    check("rst_mid_busy_pre", 64'(busy), 64'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    repeat (DIV_CYC + 2) @(negedge clk);
    check("rst_no_late_busy", 64'(busy), 64'd0);
    check("rst_no_late_hilo", {hi, lo}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
